// File: rtl/osc_decimator_pkg.sv
// Shared oscilloscope stage constants: stream/counter widths, decimation modes
// and the two's-complement saturation limits used by the osc_* stages.
package osc_decimator_pkg;

  localparam int OSC_DATA_BITS   = 16;
  localparam int OSC_CNT_BITS    = 17;
  localparam int OSC_RSHIFT_BITS = 4;

  typedef enum logic {
    MODE_PICK = 1'b0,
    MODE_AVG  = 1'b1
  } dec_mode_e;

  function automatic longint osc_sat_hi(input int bits);
    return (longint'(1) << (bits - 1)) - longint'(1);
  endfunction

  function automatic longint osc_sat_lo(input int bits);
    return -(longint'(1) << (bits - 1));
  endfunction

  localparam longint OSC_SAT_MAX = osc_sat_hi(OSC_DATA_BITS);
  localparam longint OSC_SAT_MIN = osc_sat_lo(OSC_DATA_BITS);

endpackage

// File: rtl/osc_decimator_if.sv
// Sample stream between osc stages: tdata qualified by tvalid, accepted with tready.
interface osc_decimator_if
  import osc_decimator_pkg::*;
#(
  parameter int DATA_BITS = OSC_DATA_BITS
);
  logic [DATA_BITS-1:0] tdata;
  logic                 tvalid;
  logic                 tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/osc_sat.sv
// Combinational arithmetic right shift followed by saturation to OUT_BITS signed;
// shared by osc stages that narrow a wide accumulator back to sample width.
module osc_sat
  import osc_decimator_pkg::*;
#(
  parameter int IN_BITS  = OSC_DATA_BITS + OSC_CNT_BITS,
  parameter int OUT_BITS = OSC_DATA_BITS
) (
  input  logic signed [IN_BITS-1:0]         din_i,
  input  logic        [OSC_RSHIFT_BITS-1:0] rshift_i,
  output logic signed [OUT_BITS-1:0]        dout_o
);
  localparam logic signed [IN_BITS-1:0] HI = IN_BITS'(osc_sat_hi(OUT_BITS));
  localparam logic signed [IN_BITS-1:0] LO = IN_BITS'(osc_sat_lo(OUT_BITS));

  logic signed [IN_BITS-1:0] shifted;

  always_comb begin
    shifted = din_i >>> rshift_i;
    if (shifted > HI) begin
      dout_o = OUT_BITS'(HI);
    end else if (shifted < LO) begin
      dout_o = OUT_BITS'(LO);
    end else begin
      dout_o = OUT_BITS'(shifted);
    end
  end
endmodule

// File: rtl/osc_decimator.sv
// Decimates a sample stream by N, either picking the window's last sample or
// summing the window (shift + saturate); one cycle latency, never back-pressures.
module osc_decimator
  import osc_decimator_pkg::*;
#(
  parameter int AXIS_DATA_BITS = OSC_DATA_BITS,
  parameter int CNT_BITS       = OSC_CNT_BITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  osc_decimator_if.slave             s_axis,
  osc_decimator_if.master            m_axis,
  input  logic [CNT_BITS-1:0]        cfg_dec_factor,
  input  logic [OSC_RSHIFT_BITS-1:0] cfg_dec_rshift,
  input  logic                       cfg_avg_en,
  output logic                       sts_overrun
);
  localparam int ACC_BITS = AXIS_DATA_BITS + CNT_BITS;

  logic [CNT_BITS-1:0]        dec_q;
  dec_mode_e                  mode_q;
  logic [OSC_RSHIFT_BITS-1:0] rsh_q;

  logic [CNT_BITS-1:0]        cnt_q, cnt_d, cnt_base;
  logic signed [ACC_BITS-1:0] acc_q, acc_d, sample_ext;
  logic [AXIS_DATA_BITS-1:0]  out_dat_q, out_dat_d, win_res;
  logic                       out_vld_q, out_vld_d;
  logic                       ovr_q, ovr_d;

  dec_mode_e                  mode_in, win_mode;
  logic [CNT_BITS-1:0]        win_n, last_idx;
  logic [OSC_RSHIFT_BITS-1:0] win_rsh;
  logic                       cfg_chg, win_done, xfer;
  logic signed [AXIS_DATA_BITS-1:0] avg_res;

  assign mode_in    = dec_mode_e'(cfg_avg_en);
  assign cfg_chg    = (cfg_dec_factor != dec_q) || (mode_in != mode_q) ||
                      (cfg_dec_rshift != rsh_q);

  // In the clear cycle the incoming sample already belongs to the new window,
  // so it is judged against the new configuration.
  assign win_n      = cfg_chg ? cfg_dec_factor : dec_q;
  assign win_mode   = cfg_chg ? mode_in        : mode_q;
  assign win_rsh    = cfg_chg ? cfg_dec_rshift : rsh_q;
  assign last_idx   = (win_n <= CNT_BITS'(1)) ? '0 : win_n - CNT_BITS'(1);
  assign sample_ext = ACC_BITS'(signed'(s_axis.tdata));

  always_comb begin
    cnt_base = cfg_chg ? '0 : cnt_q;
    cnt_d    = cnt_base;
    acc_d    = cfg_chg ? '0 : acc_q;
    win_done = 1'b0;
    if (s_axis.tvalid) begin
      acc_d = (cnt_base == '0) ? sample_ext : acc_q + sample_ext;
      if (cnt_base >= last_idx) begin
        cnt_d    = '0;
        win_done = 1'b1;
      end else begin
        cnt_d = cnt_base + CNT_BITS'(1);
      end
    end
  end

  osc_sat #(
    .IN_BITS  (ACC_BITS),
    .OUT_BITS (AXIS_DATA_BITS)
  ) u_sat (
    .din_i    (acc_d),
    .rshift_i (win_rsh),
    .dout_o   (avg_res)
  );

  assign win_res = (win_mode == MODE_AVG) ? avg_res : s_axis.tdata;
  assign xfer    = out_vld_q && m_axis.tready;

  always_comb begin
    out_dat_d = out_dat_q;
    out_vld_d = out_vld_q;
    ovr_d     = ovr_q;
    if (win_done) begin
      out_dat_d = win_res;
      out_vld_d = 1'b1;
      if (out_vld_q && !m_axis.tready) begin
        ovr_d = 1'b1;
      end
    end else if (xfer) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_q     <= cfg_dec_factor;
      mode_q    <= mode_in;
      rsh_q     <= cfg_dec_rshift;
      cnt_q     <= '0;
      acc_q     <= '0;
      out_dat_q <= '0;
      out_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      dec_q     <= cfg_dec_factor;
      mode_q    <= mode_in;
      rsh_q     <= cfg_dec_rshift;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      out_dat_q <= out_dat_d;
      out_vld_q <= out_vld_d;
      ovr_q     <= ovr_d;
    end
  end

  assign s_axis.tready = 1'b1;
  assign m_axis.tdata  = out_dat_q;
  assign m_axis.tvalid = out_vld_q;
  assign sts_overrun   = ovr_q;
endmodule

// File: tb/tb_osc_decimator.sv
// Self-checking bench for osc_decimator: directed scenarios plus a randomized
// mix, all checked against a window-list reference model.
module tb_osc_decimator;
  import osc_decimator_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [16:0] cfg_dec_factor = 17'd4;
  logic [3:0]  cfg_dec_rshift = 4'd0;
  logic        cfg_avg_en = 1'b0;
  logic        sts_overrun;

  osc_decimator_if #(.DATA_BITS(16)) s_if ();
  osc_decimator_if #(.DATA_BITS(16)) m_if ();

  osc_decimator dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axis         (s_if.slave),
    .m_axis         (m_if.master),
    .cfg_dec_factor (cfg_dec_factor),
    .cfg_dec_rshift (cfg_dec_rshift),
    .cfg_avg_en     (cfg_avg_en),
    .sts_overrun    (sts_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the window is a list of accepted samples; it closes when
  // the list holds N entries. Output holding follows the stream handshake.
  int          m_win[$];
  int          m_n, m_rsh;
  bit          m_avg;
  logic        m_vld;
  logic [15:0] m_dat;
  logic        m_ovr;

  function automatic int window_result();
    longint sum;
    if (!m_avg) return m_win[m_win.size() - 1];
    sum = 0;
    foreach (m_win[i]) sum += m_win[i];
    sum = sum >>> m_rsh;
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    return int'(sum);
  endfunction

  task automatic model_edge();
    int  n, res;
    bit  done;
    if (!rst_n) begin
      m_win.delete();
      m_vld = 0; m_dat = '0; m_ovr = 0;
      m_n = int'(cfg_dec_factor); m_avg = cfg_avg_en; m_rsh = int'(cfg_dec_rshift);
      return;
    end
    if (int'(cfg_dec_factor) != m_n || cfg_avg_en != m_avg || int'(cfg_dec_rshift) != m_rsh) begin
      m_win.delete();
      m_n = int'(cfg_dec_factor); m_avg = cfg_avg_en; m_rsh = int'(cfg_dec_rshift);
    end
    n = (m_n <= 1) ? 1 : m_n;
    done = 0;
    res = 0;
    if (s_if.tvalid) begin
      m_win.push_back(int'($signed(s_if.tdata)));
      if (m_win.size() == n) begin
        res = window_result();
        m_win.delete();
        done = 1;
      end
    end
    if (done) begin
      if (m_vld && !m_if.tready) m_ovr = 1;
      m_vld = 1;
      m_dat = res[15:0];
    end else if (m_vld && m_if.tready) begin
      m_vld = 0;
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d);
    s_if.tvalid = v;
    s_if.tdata  = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 16'h0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    m_if.tready = 1'b1;
    cfg_dec_factor = 17'd4; cfg_avg_en = 0; cfg_dec_rshift = 0;
    do_reset();
    checks++;
    if (m_if.tvalid !== 1'b0 || m_if.tdata !== 16'h0 || sts_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset: vld=%b dat=%h ovr=%b, want 0/0000/0", m_if.tvalid, m_if.tdata, sts_overrun);
    end
    checks++;
    if (s_if.tready !== 1'b1) begin
      errors++;
      $display("FAIL s_tready: got %b want 1", s_if.tready);
    end
  endtask

  task automatic test_pick();
    cfg_dec_factor = 17'd4; cfg_avg_en = 0; cfg_dec_rshift = 0;
    m_if.tready = 1'b1;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 16'(i));
      checks++;
      if (m_if.tvalid !== m_vld || (m_vld && m_if.tdata !== m_dat) || sts_overrun !== m_ovr) begin
        errors++;
        $display("FAIL pick cyc%0d: vld=%b dat=%h ovr=%b, want %b/%h/%b", i, m_if.tvalid, m_if.tdata, sts_overrun, m_vld, m_dat, m_ovr);
      end
      if (i == 4 || i == 8) begin
        checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 16'(i)) begin
          errors++;
          $display("FAIL pick_out%0d: vld=%b dat=%0d, want 1/%0d", i, m_if.tvalid, m_if.tdata, i);
        end
      end
    end
  endtask

  task automatic test_avg();
    int vals[4] = '{100, 200, 300, 400};
    cfg_dec_factor = 17'd4; cfg_avg_en = 1; cfg_dec_rshift = 4'd2;
    m_if.tready = 1'b1;
    do_reset();
    foreach (vals[i]) step(1'b1, 16'(vals[i]));
    checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 16'd250) begin
      errors++;
      $display("FAIL avg250: vld=%b dat=%0d, want 1/250", m_if.tvalid, m_if.tdata);
    end
    cfg_dec_rshift = 4'd0;
    step(1'b0, 16'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h8000);
    checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 16'h8000) begin
      errors++;
      $display("FAIL avg_sat: vld=%b dat=%h, want 1/8000", m_if.tvalid, m_if.tdata);
    end
    // positive saturation
    for (int i = 0; i < 4; i++) step(1'b1, 16'h7FF0);
    checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 16'h7FFF) begin
      errors++;
      $display("FAIL avg_sat_hi: vld=%b dat=%h, want 1/7fff", m_if.tvalid, m_if.tdata);
    end
  endtask

  task automatic test_n1_stream();
    logic [15:0] d;
    int bad = 0;
    cfg_dec_factor = 17'd1; cfg_avg_en = 0; cfg_dec_rshift = 0;
    m_if.tready = 1'b1;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      d = 16'($urandom);
      step(1'b1, d);
      checks++;
      if (m_if.tvalid !== 1'b1 || m_if.tdata !== d || sts_overrun !== 1'b0) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL n1 #%0d: vld=%b dat=%h ovr=%b, want 1/%h/0", i, m_if.tvalid, m_if.tdata, sts_overrun, d);
      end
    end
  endtask

  task automatic test_overrun();
    logic [15:0] d = '0;
    cfg_dec_factor = 17'd2; cfg_avg_en = 0; cfg_dec_rshift = 0;
    m_if.tready = 1'b1;
    do_reset();
    m_if.tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = 16'($urandom);
      step(1'b1, d);
      checks++;
      if (m_if.tvalid !== m_vld || (m_vld && m_if.tdata !== m_dat) || sts_overrun !== m_ovr) begin
        errors++;
        $display("FAIL ovr cyc%0d: vld=%b dat=%h ovr=%b, want %b/%h/%b", i, m_if.tvalid, m_if.tdata, sts_overrun, m_vld, m_dat, m_ovr);
      end
    end
    checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== d || sts_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_hold: vld=%b dat=%h ovr=%b, want 1/%h/1", m_if.tvalid, m_if.tdata, sts_overrun, d);
    end
    m_if.tready = 1'b1;
    step(1'b0, 16'h0);
    checks++;
    if (m_if.tvalid !== 1'b0 || sts_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_xfer: vld=%b ovr=%b, want 0/1", m_if.tvalid, sts_overrun);
    end
  endtask

  task automatic test_cfg_change();
    logic [15:0] a, b;
    cfg_dec_factor = 17'd8; cfg_avg_en = 0; cfg_dec_rshift = 0;
    m_if.tready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom));
    cfg_dec_factor = 17'd3;
    step(1'b0, 16'h0);
    for (int i = 1; i <= 3; i++) begin
      a = 16'($urandom);
      step(1'b1, a);
      checks++;
      if (m_if.tvalid !== (i == 3) || (i == 3 && m_if.tdata !== a)) begin
        errors++;
        $display("FAIL cfg_chg s%0d: vld=%b dat=%h, want %b/%h", i, m_if.tvalid, m_if.tdata, (i == 3), a);
      end
    end
    // a sample in the clear cycle opens the new window
    cfg_dec_factor = 17'd2;
    a = 16'($urandom);
    step(1'b1, a);
    checks++;
    if (m_if.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL clr_sample: vld=%b, want 0", m_if.tvalid);
    end
    b = 16'($urandom);
    step(1'b1, b);
    checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== b) begin
      errors++;
      $display("FAIL clr_window: vld=%b dat=%h, want 1/%h", m_if.tvalid, m_if.tdata, b);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    cfg_dec_factor = 17'd4; cfg_avg_en = 0; cfg_dec_rshift = 0;
    m_if.tready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 16'($urandom));
    rst_n = 1'b0;
    step(1'b1, 16'h1234);
    rst_n = 1'b1;
    checks++;
    if (m_if.tvalid !== 1'b0 || sts_overrun !== 1'b0 || m_if.tdata !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid: vld=%b ovr=%b dat=%h, want 0/0/0000", m_if.tvalid, sts_overrun, m_if.tdata);
    end
    m_if.tready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      d = 16'($urandom);
      step(1'b1, d);
      checks++;
      if (m_if.tvalid !== (i == 4) || (i == 4 && m_if.tdata !== d)) begin
        errors++;
        $display("FAIL rst_win s%0d: vld=%b dat=%h, want %b/%h", i, m_if.tvalid, m_if.tdata, (i == 4), d);
      end
    end
  endtask

  task automatic test_random_mix();
    int ns[6] = '{0, 1, 2, 3, 5, 7};
    int bad = 0;
    cfg_dec_factor = 17'd3; cfg_avg_en = 1; cfg_dec_rshift = 4'd1;
    m_if.tready = 1'b1;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        cfg_dec_factor = 17'(ns[$urandom_range(0, 5)]);
        cfg_avg_en     = 1'($urandom_range(0, 1));
        cfg_dec_rshift = 4'($urandom_range(0, 4));
      end
      m_if.tready = ($urandom_range(0, 99) < 60);
      step(($urandom_range(0, 99) < 75), 16'($urandom));
      checks++;
      if (m_if.tvalid !== m_vld || (m_vld && m_if.tdata !== m_dat) || sts_overrun !== m_ovr) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL mix cyc%0d: vld=%b dat=%h ovr=%b, want %b/%h/%b", i, m_if.tvalid, m_if.tdata, sts_overrun, m_vld, m_dat, m_ovr);
      end
    end
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b1;
    test_reset();
    test_pick();
    test_avg();
    test_n1_stream();
    test_overrun();
    test_cfg_change();
    test_reset_mid();
    test_random_mix();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/osc_decimator.md
OSC_DECIMATOR -- requirements
Module: osc_decimator

Interface
REQ-001 The block SHALL have parameter AXIS_DATA_BITS, default 16, meaning sample width of input and output streams (two's complement).
REQ-002 The block SHALL have parameter CNT_BITS, default 17, meaning width of the decimation factor and sample counter.
REQ-003 The block SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port s_axis_tdata  input  AXIS_DATA_BITS  filtered sample from upstream filter stage.
REQ-006 The block SHALL have port s_axis_tvalid  input  1  input sample valid.
REQ-007 The block SHALL have port s_axis_tready  output  1  tied constant 1; the block never back-pressures.
REQ-008 The block SHALL have port m_axis_tdata  output  AXIS_DATA_BITS  decimated sample.
REQ-009 The block SHALL have port m_axis_tvalid  output  1  decimated sample valid.
REQ-010 The block SHALL have port m_axis_tready  input  1  downstream accepts sample.
REQ-011 The block SHALL have port cfg_dec_factor  input  CNT_BITS  decimation factor N; values 0 and 1 both mean N=1.
REQ-012 The block SHALL have port cfg_dec_rshift  input  4  arithmetic right shift applied to the window sum in averaging mode.
REQ-013 The block SHALL have port cfg_avg_en  input  1  1 = average (sum) the window, 0 = pick the last sample of the window.
REQ-014 The block SHALL have port sts_overrun  output  1  sticky flag: an output sample was overwritten before acceptance.

Function
REQ-015 A sample SHALL be accepted on every cycle with s_axis_tvalid=1.
REQ-016 A sample counter SHALL count accepted samples 0..N-1; the sample accepted at count N-1 closes the window and the counter returns to 0.
REQ-017 With cfg_avg_en=0, the window result SHALL be the closing sample, unmodified.
REQ-018 With cfg_avg_en=1, a signed accumulator of AXIS_DATA_BITS+CNT_BITS bits SHALL sum all N samples of the window without overflow; result = sum >>> cfg_dec_rshift, saturated to 0x7FFF / 0x8000.
REQ-019 The accumulator SHALL be reloaded with the first sample of each window, not cleared and then added.
REQ-020 The window result SHALL appear on m_axis_tdata with m_axis_tvalid=1 exactly one cycle after the closing sample is accepted.
REQ-021 m_axis_tvalid and m_axis_tdata SHALL hold while m_axis_tready=0; the sample transfers on a cycle with m_axis_tvalid=1 and m_axis_tready=1, after which m_axis_tvalid deasserts unless a new result loads the same cycle.
REQ-022 If a new result loads while m_axis_tvalid=1 and m_axis_tready=0, the new result SHALL overwrite m_axis_tdata, m_axis_tvalid SHALL stay 1, and sts_overrun SHALL set.
REQ-023 A result that loads in the same cycle as a transfer SHALL not set sts_overrun.
REQ-024 With N=1, every accepted sample SHALL produce one output, one cycle of latency.
REQ-025 cfg_dec_factor, cfg_avg_en and cfg_dec_rshift SHALL be registered; a change of any of them (registered value differs from the input) SHALL clear the counter and accumulator on the following cycle and discard the partial window, without affecting an output already pending.
REQ-026 A sample accepted in the clear cycle SHALL start a new window.

Reset
REQ-027 On rst_n=0, the block SHALL set m_axis_tvalid=0, m_axis_tdata=0, sts_overrun=0, counter=0, accumulator=0, and load the config registers from their inputs.
REQ-028 The block SHALL discard any partial window and any pending output when reset is asserted mid-operation; the first window after reset starts with the first sample accepted once rst_n=1.

Structure
REQ-029 AXIS_DATA_BITS, CNT_BITS and the saturation limits SHALL come from the shared oscilloscope constants include used by the osc_* stages.
REQ-030 Saturation and shift SHALL be one combinational sub-module, osc_sat, reusable by other osc stages; counter, accumulator and output register stay in osc_decimator.

Verification
REQ-031 N=4, avg_en=0, inputs 1,2,3,4,5,6,7,8 on consecutive cycles, tready=1 -> outputs 4 then 8, each 1 cycle after the 4th/8th input.
REQ-032 N=4, avg_en=1, rshift=2, inputs 100,200,300,400 -> single output 250; inputs -32768 x4, rshift=0 -> output saturates to 0x8000.
REQ-033 N=1, random stream of 1000 samples -> output equals input delayed by 1 cycle, sts_overrun stays 0.
REQ-034 N=2, tready held 0 for 6 input cycles -> m_axis_tdata shows the latest result, tvalid=1, sts_overrun=1; raising tready transfers one sample, and tvalid drops next cycle.
REQ-035 N=8, change cfg_dec_factor to 3 after 5 samples -> partial window discarded; next output after 3 further samples following the clear cycle.
REQ-036 Assert rst_n=0 for 1 cycle mid-window (N=4, 2 samples in) -> tvalid=0, sts_overrun=0; next output after 4 post-reset samples.
